dlfloat16_normalize: RTL and testbench

//  Producer end of the DLFloat16 rounding interface. Takes an unnormalised wide magnitude, sign and biased exponent from
//  the add/mul datapath and normalises it over several cycles (multi-cycle leading-zero shifter).

---
 rtl/dlfloat16_pkg.sv | 39 +++
 rtl/dlfloat16_grs_pack.sv | 51 +++++
 rtl/dlfloat16_normalize.sv | 133 +++++++++++++
 tb/tb_dlfloat16_normalize.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dlfloat16_pkg.sv
// DLFloat16 shared definitions: format constants, FSM states and the pre-round word layout.
package dlfloat16_pkg;

   localparam int DLF16_BIAS    = 31;
   localparam int DLF16_EXP_W   = 6;
   localparam int DLF16_MAN_W   = 9;
   localparam int DLF16_EXP_MAX = 63;
   localparam logic [DLF16_MAN_W-1:0] DLF16_MAN_MAX = 9'h1FE;

   localparam int PR_SIGN   = 19;
   localparam int PR_EXP_HI = 18;
   localparam int PR_EXP_LO = 13;
   localparam int PR_MAN_HI = 12;
   localparam int PR_MAN_LO = 4;
   localparam int PR_G      = 3;
   localparam int PR_R      = 2;
   localparam int PR_S1     = 1;
   localparam int PR_S2     = 0;

   typedef enum logic [1:0] {IDLE, NORM, OUT} norm_state_e;

   // Field order matches the PR_* bit positions above.
   typedef struct packed {
      logic                   sign;
      logic [DLF16_EXP_W-1:0] exp;
      logic [DLF16_MAN_W-1:0] man;
      logic                   g;
      logic                   r;
      logic                   s1;
      logic                   s2;
   } preround_t;

   typedef struct packed {
      logic ovf;
      logic unf;
      logic zero;
   } norm_flags_t;

endpackage

// File: rtl/dlfloat16_grs_pack.sv
// Packs a normalised magnitude into the 20-bit DLFloat16 pre-round word,
// saturating on exponent overflow and flushing to signed zero on underflow.
module dlfloat16_grs_pack
   import dlfloat16_pkg::*;
#(
   parameter int MW = 24,
   parameter int EW = 8
) (
   input  logic [MW-1:0]        m_i,
   input  logic signed [EW+1:0] e_i,
   input  logic                 st_i,
   input  logic                 sign_i,
   output preround_t            word_o,
   output norm_flags_t          flags_o
);

   localparam logic signed [EW+1:0] EMAX = (EW+2)'(DLF16_EXP_MAX);

   logic s2;

   generate
      if (MW > 15) begin : g_s2_tail
         assign s2 = (|m_i[MW-15:0]) | st_i;
      end else begin : g_s2_st
         assign s2 = st_i;
      end
   endgenerate

   always_comb begin
      word_o      = '0;
      flags_o     = '0;
      word_o.sign = sign_i;
      if (m_i == '0) begin
         flags_o.zero = 1'b1;
      end else if (e_i > EMAX) begin
         flags_o.ovf = 1'b1;
         word_o.exp  = DLF16_EXP_W'(DLF16_EXP_MAX);
         word_o.man  = DLF16_MAN_MAX;
      end else if (e_i[EW+1]) begin
         flags_o.unf = 1'b1;
      end else begin
         word_o.exp = e_i[DLF16_EXP_W-1:0];
         word_o.man = m_i[MW-3 -: DLF16_MAN_W];
         word_o.g   = m_i[MW-12];
         word_o.r   = m_i[MW-13];
         word_o.s1  = m_i[MW-14];
         word_o.s2  = s2;
      end
   end

endmodule

// File: rtl/dlfloat16_normalize.sv
// Multi-cycle leading-zero normaliser feeding the DLFloat16 rounding stage.
// Define DLF16_NORM_FLAGS_EN to add the registered {ovf,unf,zero} out_flags port.
module dlfloat16_normalize
   import dlfloat16_pkg::*;
#(
   parameter int MW         = 24,
   parameter int EW         = 8,
   parameter int SHIFT_STEP = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_sign,
   input  logic [EW-1:0] in_exp,
   input  logic [MW-1:0] in_mant,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_data
`ifdef DLF16_NORM_FLAGS_EN
  ,output logic [2:0]    out_flags
`endif
);

   localparam int EXW = EW + 2;

   norm_state_e     state_q, state_d;
   logic [MW-1:0]   m_q, m_d;
   logic [EXW-1:0]  e_q, e_d;
   logic            st_q, st_d;
   logic            sign_q, sign_d;
   logic [31:0]     data_q, data_d;

   logic [MW-1:0]   pk_m;
   logic [EXW-1:0]  pk_e;
   logic            pk_st;
   preround_t       pk_word;
   norm_flags_t     pk_flags;

   // An overflowed magnitude is right-shifted into the packer in the same cycle.
   always_comb begin
      pk_m  = m_q;
      pk_e  = e_q;
      pk_st = st_q;
      if (m_q[MW-1]) begin
         pk_m  = m_q >> 1;
         pk_e  = e_q + EXW'(1);
         pk_st = st_q | m_q[0];
      end
   end

   dlfloat16_grs_pack #(.MW(MW), .EW(EW)) u_pack (
      .m_i     (pk_m),
      .e_i     (pk_e),
      .st_i    (pk_st),
      .sign_i  (sign_q),
      .word_o  (pk_word),
      .flags_o (pk_flags)
   );

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      e_d     = e_q;
      st_d    = st_q;
      sign_d  = sign_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               m_d     = in_mant;
               e_d     = {{2{in_exp[EW-1]}}, in_exp};
               st_d    = 1'b0;
               sign_d  = in_sign;
               state_d = NORM;
            end
         end
         NORM: begin
            if (m_q == '0 || m_q[MW-1] || m_q[MW-2]) begin
               data_d  = {12'h000, pk_word};
               state_d = OUT;
            end else if (m_q[MW-2 -: SHIFT_STEP] == '0) begin
               m_d = m_q << SHIFT_STEP;
               e_d = e_q - EXW'(SHIFT_STEP);
            end else begin
               m_d = m_q << 1;
               e_d = e_q - EXW'(1);
            end
         end
         OUT: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         m_q     <= '0;
         e_q     <= '0;
         st_q    <= 1'b0;
         sign_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         e_q     <= e_d;
         st_q    <= st_d;
         sign_q  <= sign_d;
         data_q  <= data_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == OUT);
   assign out_data  = data_q;

`ifdef DLF16_NORM_FLAGS_EN
   norm_flags_t flags_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                                   flags_q <= '0;
      else if (state_q == NORM && (m_q == '0 || m_q[MW-1] || m_q[MW-2])) flags_q <= pk_flags;
   end

   assign out_flags = flags_q;
`else
   logic unused_flags;
   assign unused_flags = ^pk_flags;
`endif

endmodule

// File: tb/tb_dlfloat16_normalize.sv
// Directed-vector bench for dlfloat16_normalize with an arithmetic reference model and per-cycle compare.
module tb_dlfloat16_normalize;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [7:0]  in_exp;
   logic [23:0] in_mant;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
`ifdef DLF16_NORM_FLAGS_EN
   logic [2:0]  out_flags;
`endif

   always #5 clk = ~clk;

   dlfloat16_normalize #(.MW(24), .EW(8), .SHIFT_STEP(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_mant   (in_mant),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef DLF16_NORM_FLAGS_EN
     ,.out_flags (out_flags)
`endif
   );

   typedef struct {
      logic [31:0] data;
      logic [2:0]  flags;
      int          k;
      int          acc;
      logic [31:0] lit;
      bit          has_lit;
   } item_t;

   item_t q[$];
   item_t cur;
   bit    seen = 0;
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: locate the leading one, normalise by plain shifting, then count cycles.
   function automatic item_t model(input bit s, input logic [7:0] ex, input logic [23:0] mt);
      item_t r;
      int e, p, d, mn;
      bit st;
      r = '{default: 0};
      e  = int'($signed(ex));
      st = 0;
      if (mt == 0) begin
         r.data  = 32'(s) << 19;
         r.flags = 3'b001;
         return r;
      end
      p = 23;
      while (!mt[p]) p--;
      if (p == 23) begin
         st = mt[0];
         mn = int'(mt >> 1);
         e  = e + 1;
      end else begin
         d   = 22 - p;
         r.k = d / 4 + d % 4;
         mn  = int'(mt) << d;
         e   = e - d;
      end
      if (e > 63) begin
         r.data  = (32'(s) << 19) | (32'd63 << 13) | (32'h1FE << 4);
         r.flags = 3'b100;
      end else if (e < 0) begin
         r.data  = 32'(s) << 19;
         r.flags = 3'b010;
      end else begin
         r.data = (32'(s) << 19) | (32'(e) << 13) | (32'((mn >> 13) & 'h1FF) << 4)
                | (32'((mn >> 12) & 1) << 3) | (32'((mn >> 11) & 1) << 2)
                | (32'((mn >> 10) & 1) << 1) | 32'(((mn & 'h3FF) != 0) || st);
         r.flags = 3'b000;
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (!seen) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_out got=%h want=none", out_data);
            end else begin
               cur  = q.pop_front();
               seen = 1;
               chk("latency", 32'(cyc - cur.acc), 32'(cur.k + 1));
               if (cur.has_lit) chk("literal", out_data, cur.lit);
            end
         end
         if (seen) begin
            chk("data", out_data, cur.data);
            chk("in_ready_busy", 32'(in_ready), 32'd0);
`ifdef DLF16_NORM_FLAGS_EN
            chk("flags", 32'(out_flags), 32'(cur.flags));
`endif
            if (out_ready) seen = 0;
         end
      end
   end

   task automatic send(input bit s, input logic [7:0] ex, input logic [23:0] mt,
                       input logic [31:0] lit, input bit has_lit);
      item_t it;
      it = model(s, ex, mt);
      it.lit = lit;
      it.has_lit = has_lit;
      in_sign  = s;
      in_exp   = ex;
      in_mant  = mt;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      it.acc = cyc;
      q.push_back(it);
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL timeout got=busy want=idle");
      end
   endtask

   task automatic run(input bit s, input logic [7:0] ex, input logic [23:0] mt,
                      input logic [31:0] lit);
      send(s, ex, mt, lit, 1'b1);
      wait_idle();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sign   = 1'b0;
      in_exp    = '0;
      in_mant   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
`ifdef DLF16_NORM_FLAGS_EN
      chk("rst_flags", 32'(out_flags), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run(1'b0, 8'd31,  24'h400000, 32'h0003E000);
      run(1'b0, 8'd31,  24'h800001, 32'h00040001);
      run(1'b1, 8'd31,  24'h000001, 32'h00092000);
      run(1'b0, 8'd70,  24'h400000, 32'h0007FFE0);
      run(1'b1, 8'd70,  24'h400000, 32'h000FFFE0);
      run(1'b0, 8'd10,  24'h000001, 32'h00000000);
      run(1'b1, 8'd31,  24'h000000, 32'h00080000);
      run(1'b0, 8'd31,  24'h5ABCDE, 32'h0003ED5F);
      run(1'b0, 8'd31,  24'h200000, 32'h0003C000);
      run(1'b0, 8'd31,  24'h040000, 32'h00036000);
      run(1'b0, 8'd63,  24'h400000, 32'h0007E000);
      run(1'b0, 8'd63,  24'h800000, 32'h0007FFE0);
      run(1'b0, 8'hFB,  24'h400000, 32'h00000000);

      // Back-pressure: result must hold while out_ready is low.
      out_ready = 1'b0;
      send(1'b0, 8'd31, 24'h5ABCDE, 32'h0003ED5F, 1'b1);
      for (int i = 0; i < 20 && !out_valid; i++) begin
         @(posedge clk);
         #1;
      end
      chk("hold_valid", 32'(out_valid), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("hold_data", out_data, 32'h0003ED5F);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      wait_idle();

      // Abort a long normalisation with reset.
      send(1'b1, 8'd31, 24'h000001, 32'h00092000, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_out_data", out_data, 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd1);
`ifdef DLF16_NORM_FLAGS_EN
      chk("abort_flags", 32'(out_flags), 32'd0);
`endif
      q.delete();
      seen = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (10) @(posedge clk);
      #1;
      chk("abort_no_emit", 32'(out_valid), 32'd0);

      run(1'b0, 8'd31, 24'h200000, 32'h0003C000);
      chk("queue_drained", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
